// File: rtl/regfile_mc.sv
// Multicycle-CPU register file: two write ports, destination/data muxes with a
// link register, write-to-read bypass and optional A/B output latches.
module regfile_mc #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int LINK_REG = 31,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   parameter int READ_REG = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWrite,
   input  logic [1:0]        wdst_sel,
   input  logic [1:0]        wdata_sel,
   input  logic [DATA_W-1:0] data_alu,
   input  logic [DATA_W-1:0] data_dm,
   input  logic [DATA_W-1:0] data_pc,
   input  logic              we1,
   input  logic [ADDR_W-1:0] waddr1,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   input  logic [ADDR_W-1:0] rd,
   input  logic              lat_en,
   output logic [DATA_W-1:0] rs_out,
   output logic [DATA_W-1:0] rt_out
);

   localparam int                DEPTH  = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
   localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
   localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [ADDR_W-1:0] dst0_s;
   logic [DATA_W-1:0] sel_data_s;
   logic              wen0_s;
   logic              wen1_s;
   logic [DATA_W-1:0] rs_d;
   logic [DATA_W-1:0] rt_d;

   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == ZERO_A);
   endfunction

   // Port 0 has priority over port 1, both in the array and on the bypass path.
   function automatic logic [DATA_W-1:0] read_port(
      input logic [ADDR_W-1:0] a,
      input logic [DATA_W-1:0] arr_v,
      input logic              w0,
      input logic [ADDR_W-1:0] a0,
      input logic [DATA_W-1:0] d0,
      input logic              w1,
      input logic [ADDR_W-1:0] a1,
      input logic [DATA_W-1:0] d1
   );
      logic [DATA_W-1:0] v;
      if (is_zero(a)) begin
         v = ZERO_D;
      end else if ((BYPASS != 0) && w0 && (a0 == a)) begin
         v = d0;
      end else if ((BYPASS != 0) && w1 && (a1 == a)) begin
         v = d1;
      end else begin
         v = arr_v;
      end
      return v;
   endfunction

   // Port-0 destination/data muxes and the masked write enables of both ports.
   always_comb begin
      dst0_s     = ZERO_A;
      sel_data_s = data_alu;
      case (wdst_sel)
         2'd0:    dst0_s = rt;
         2'd1:    dst0_s = rd;
         2'd2:    dst0_s = LINK_A;
         default: dst0_s = ZERO_A;
      endcase
      case (wdata_sel)
         2'd1:    sel_data_s = data_dm;
         2'd2:    sel_data_s = data_pc;
         default: sel_data_s = data_alu;
      endcase
      if (!reset && RegWrite && (wdst_sel != 2'd3) && !is_zero(dst0_s)) begin
         wen0_s = 1'b1;
      end else begin
         wen0_s = 1'b0;
      end
      if (!reset && we1 && !is_zero(waddr1) && !(wen0_s && (dst0_s == waddr1))) begin
         wen1_s = 1'b1;
      end else begin
         wen1_s = 1'b0;
      end
   end

   // Bypassed read values feeding either the latches or the outputs directly.
   always_comb begin
      rs_d = read_port(rs, regs_q[rs], wen0_s, dst0_s, sel_data_s, wen1_s, waddr1, wdata1);
      rt_d = read_port(rt, regs_q[rt], wen0_s, dst0_s, sel_data_s, wen1_s, waddr1, wdata1);
   end

   // Register array: cleared on reset, written by both ports otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= ZERO_D;
         end
      end else begin
         if (wen0_s) begin
            regs_q[dst0_s] <= sel_data_s;
         end
         if (wen1_s) begin
            regs_q[waddr1] <= wdata1;
         end
      end
   end

   generate
      if (READ_REG != 0) begin : g_latch
         logic [DATA_W-1:0] rs_q;
         logic [DATA_W-1:0] rt_q;

         // A/B latches of the multicycle datapath.
         always_ff @(posedge clk) begin
            if (reset) begin
               rs_q <= ZERO_D;
               rt_q <= ZERO_D;
            end else if (lat_en) begin
               rs_q <= rs_d;
               rt_q <= rt_d;
            end
         end

         assign rs_out = rs_q;
         assign rt_out = rt_q;
      end else begin : g_comb
         assign rs_out = rs_d;
         assign rt_out = rt_d;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_mc.sv
// Directed bench for regfile_mc: a vector table on the default configuration plus
// side instances with BYPASS=0, ZERO_REG=0 and READ_REG=0.
module tb_regfile_mc;

   logic        clk = 1'b0;
   logic        reset;
   logic        RegWrite;
   logic [1:0]  wdst_sel;
   logic [1:0]  wdata_sel;
   logic [31:0] data_alu, data_dm, data_pc, wdata1;
   logic        we1;
   logic [4:0]  waddr1, rs, rt, rd;
   logic        lat_en;
   logic [31:0] rs_out, rt_out, nb_rs, nb_rt, nz_rs, nz_rt, cb_rs, cb_rt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   regfile_mc dut (
      .clk(clk), .reset(reset), .RegWrite(RegWrite), .wdst_sel(wdst_sel), .wdata_sel(wdata_sel),
      .data_alu(data_alu), .data_dm(data_dm), .data_pc(data_pc), .we1(we1), .waddr1(waddr1),
      .wdata1(wdata1), .rs(rs), .rt(rt), .rd(rd), .lat_en(lat_en), .rs_out(rs_out), .rt_out(rt_out)
   );

   regfile_mc #(.BYPASS(0)) dut_nb (
      .clk(clk), .reset(reset), .RegWrite(RegWrite), .wdst_sel(wdst_sel), .wdata_sel(wdata_sel),
      .data_alu(data_alu), .data_dm(data_dm), .data_pc(data_pc), .we1(we1), .waddr1(waddr1),
      .wdata1(wdata1), .rs(rs), .rt(rt), .rd(rd), .lat_en(lat_en), .rs_out(nb_rs), .rt_out(nb_rt)
   );

   regfile_mc #(.ZERO_REG(0)) dut_nz (
      .clk(clk), .reset(reset), .RegWrite(RegWrite), .wdst_sel(wdst_sel), .wdata_sel(wdata_sel),
      .data_alu(data_alu), .data_dm(data_dm), .data_pc(data_pc), .we1(we1), .waddr1(waddr1),
      .wdata1(wdata1), .rs(rs), .rt(rt), .rd(rd), .lat_en(lat_en), .rs_out(nz_rs), .rt_out(nz_rt)
   );

   regfile_mc #(.READ_REG(0)) dut_cb (
      .clk(clk), .reset(reset), .RegWrite(RegWrite), .wdst_sel(wdst_sel), .wdata_sel(wdata_sel),
      .data_alu(data_alu), .data_dm(data_dm), .data_pc(data_pc), .we1(we1), .waddr1(waddr1),
      .wdata1(wdata1), .rs(rs), .rt(rt), .rd(rd), .lat_en(lat_en), .rs_out(cb_rs), .rt_out(cb_rt)
   );

   typedef struct {
      logic        rst;
      logic        rw;
      logic [1:0]  dsel;
      logic [1:0]  dtsel;
      logic [31:0] alu;
      logic [31:0] dm;
      logic [31:0] pc;
      logic        w1;
      logic [4:0]  a1;
      logic [31:0] d1;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [4:0]  rdst;
      logic        le;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic        chk_nb;
      logic [31:0] exp_nb;
      logic        chk_nz;
      logic [31:0] exp_nz;
   } vec_t;

   vec_t vec [22];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      reset = v.rst;   RegWrite = v.rw;   wdst_sel = v.dsel;  wdata_sel = v.dtsel;
      data_alu = v.alu; data_dm = v.dm;   data_pc = v.pc;     we1 = v.w1;
      waddr1 = v.a1;   wdata1 = v.d1;     rs = v.ra;          rt = v.rb;
      rd = v.rdst;     lat_en = v.le;
   endtask

   task automatic idle();
      reset = 1'b0; RegWrite = 1'b0; wdst_sel = 2'd3; wdata_sel = 2'd0;
      data_alu = 32'h0; data_dm = 32'h0; data_pc = 32'h0; we1 = 1'b0;
      waddr1 = 5'd0; wdata1 = 32'h0; rs = 5'd0; rt = 5'd0; rd = 5'd0; lat_en = 1'b0;
   endtask

   initial begin
      //          rst   rw    dsel  dtsel alu           dm            pc            w1    a1     d1            rs     rt     rd     le    exp_a         exp_b         nb    exp_nb        nz    exp_nz
      vec[0]  = '{1'b1, 1'b1, 2'd1, 2'd0, 32'h0000_1111, 32'h0,       32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  5'd5,  1'b1, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
      vec[1]  = '{1'b1, 1'b1, 2'd1, 2'd0, 32'h0000_1111, 32'h0,       32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  5'd5,  1'b1, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
      vec[2]  = '{1'b0, 1'b0, 2'd1, 2'd0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  5'd5,  1'b1, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
      vec[3]  = '{1'b0, 1'b1, 2'd0, 2'd1, 32'h0,        32'h1111_0000, 32'h0,       1'b0, 5'd0,  32'h0,        5'd5,  5'd4,  5'd6,  1'b0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
      vec[4]  = '{1'b0, 1'b0, 2'd0, 2'd0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        5'd4,  5'd4,  5'd6,  1'b1, 32'h1111_0000, 32'h1111_0000, 1'b1, 32'h1111_0000, 1'b0, 32'h0};
      vec[5]  = '{1'b0, 1'b1, 2'd2, 2'd2, 32'h0,        32'h0,        32'h0040_0008, 1'b0, 5'd0, 32'h0,        5'd4,  5'd4,  5'd6,  1'b0, 32'h1111_0000, 32'h1111_0000, 1'b0, 32'h0,       1'b0, 32'h0};
      vec[6]  = '{1'b0, 1'b1, 2'd3, 2'd0, 32'hBAD0_0BAD, 32'h0,       32'h0,        1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 5'd6,  1'b1, 32'h0040_0008, 32'h0040_0008, 1'b0, 32'h0,       1'b0, 32'h0};
      vec[7]  = '{1'b0, 1'b0, 2'd3, 2'd0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        5'd31, 5'd0,  5'd6,  1'b1, 32'h0040_0008, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
      vec[8]  = '{1'b0, 1'b0, 2'd3, 2'd0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        5'd6,  5'd4,  5'd6,  1'b1, 32'h0,        32'h1111_0000, 1'b0, 32'h0,        1'b0, 32'h0};
      vec[9]  = '{1'b0, 1'b1, 2'd1, 2'd0, 32'hAAAA_AAAA, 32'h0,       32'h0,        1'b1, 5'd7,  32'h5555_5555, 5'd6,  5'd4,  5'd7,  1'b0, 32'h0,        32'h1111_0000, 1'b0, 32'h0,        1'b0, 32'h0};
      vec[10] = '{1'b0, 1'b0, 2'd3, 2'd0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  5'd7,  1'b1, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b1, 32'hAAAA_AAAA, 1'b0, 32'h0};
      vec[11] = '{1'b0, 1'b1, 2'd1, 2'd0, 32'h1234_5678, 32'h0,       32'h0,        1'b1, 5'd8,  32'h8765_4321, 5'd7,  5'd7,  5'd7,  1'b0, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0, 32'h0,       1'b0, 32'h0};
      vec[12] = '{1'b0, 1'b0, 2'd3, 2'd0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd8,  5'd7,  1'b1, 32'h1234_5678, 32'h8765_4321, 1'b0, 32'h0,       1'b0, 32'h0};
      vec[13] = '{1'b0, 1'b1, 2'd1, 2'd0, 32'hDEAD_BEEF, 32'h0,       32'h0,        1'b0, 5'd0,  32'h0,        5'd9,  5'd9,  5'd9,  1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 32'h0,       1'b0, 32'h0};
      vec[14] = '{1'b0, 1'b1, 2'd1, 2'd3, 32'h0A0A_0A0A, 32'h0,       32'h0,        1'b1, 5'd11, 32'h0B0B_0B0B, 5'd10, 5'd11, 5'd10, 1'b1, 32'h0A0A_0A0A, 32'h0B0B_0B0B, 1'b1, 32'h0,      1'b0, 32'h0};
      vec[15] = '{1'b0, 1'b1, 2'd1, 2'd0, 32'hC0C0_C0C0, 32'h0,       32'h0,        1'b1, 5'd12, 32'h0C0C_0C0C, 5'd12, 5'd12, 5'd12, 1'b1, 32'hC0C0_C0C0, 32'hC0C0_C0C0, 1'b0, 32'h0,      1'b0, 32'h0};
      vec[16] = '{1'b0, 1'b1, 2'd1, 2'd0, 32'hFFFF_FFFF, 32'h0,       32'h0,        1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  5'd0,  1'b1, 32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 32'hFFFF_FFFF};
      vec[17] = '{1'b0, 1'b0, 2'd3, 2'd0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd9,  5'd0,  1'b1, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFF};
      vec[18] = '{1'b0, 1'b1, 2'd3, 2'd0, 32'h0,        32'h0,        32'h0,        1'b1, 5'd13, 32'h1313_1313, 5'd13, 5'd13, 5'd0,  1'b0, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'h0,        1'b0, 32'h0};
      vec[19] = '{1'b0, 1'b0, 2'd3, 2'd0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        5'd13, 5'd12, 5'd0,  1'b1, 32'h1313_1313, 32'hC0C0_C0C0, 1'b1, 32'h1313_1313, 1'b0, 32'h0};
      vec[20] = '{1'b1, 1'b1, 2'd1, 2'd0, 32'h7777_7777, 32'h0,       32'h0,        1'b1, 5'd31, 32'h3131_3131, 5'd7,  5'd31, 5'd7,  1'b1, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
      vec[21] = '{1'b0, 1'b0, 2'd3, 2'd0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd31, 5'd0,  1'b1, 32'h0,        32'h0,        1'b1, 32'h0,        1'b0, 32'h0};

      idle();
      @(posedge clk);
      #1;
      for (int i = 0; i < 22; i++) begin
         apply(vec[i]);
         @(posedge clk);
         #1;
         check($sformatf("v%0d rs_out", i), rs_out, vec[i].exp_a);
         check($sformatf("v%0d rt_out", i), rt_out, vec[i].exp_b);
         if (vec[i].chk_nb) check($sformatf("v%0d nobypass rs_out", i), nb_rs, vec[i].exp_nb);
         if (vec[i].chk_nz) check($sformatf("v%0d nozero rs_out", i), nz_rs, vec[i].exp_nz);
      end

      // Combinational-read instance: array was just reset, bypass visible before the edge.
      idle();
      rs = 5'd3; rt = 5'd31;
      #1;
      check("comb after reset rs", cb_rs, 32'h0);
      check("comb after reset rt", cb_rt, 32'h0);
      RegWrite = 1'b1; wdst_sel = 2'd1; rd = 5'd3; data_alu = 32'h3333_3333;
      we1 = 1'b1; waddr1 = 5'd31; wdata1 = 32'h3131_3131;
      #1;
      check("comb bypass p0", cb_rs, 32'h3333_3333);
      check("comb bypass p1", cb_rt, 32'h3131_3131);
      @(posedge clk);
      #1;
      idle();
      rs = 5'd3; rt = 5'd31;
      #1;
      check("comb array rs", cb_rs, 32'h3333_3333);
      check("comb array rt", cb_rt, 32'h3131_3131);

      // Latched outputs hold over several cycles while the register underneath changes.
      lat_en = 1'b1;
      @(posedge clk);
      #1;
      check("latch load", rs_out, 32'h3333_3333);
      lat_en = 1'b0; RegWrite = 1'b1; wdst_sel = 2'd1; rd = 5'd3; data_alu = 32'h4444_4444;
      repeat (3) @(posedge clk);
      #1;
      check("latch hold", rs_out, 32'h3333_3333);
      check("comb sees new", cb_rs, 32'h4444_4444);
      RegWrite = 1'b0; lat_en = 1'b1;
      @(posedge clk);
      #1;
      check("latch reload", rs_out, 32'h4444_4444);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
